// File: rtl/maxpool_2x2_line.sv
// 2x2 / stride-2 signed max-pool over one pair of conv-output line BRAMs (3 channels).
// Streams floor(INWIDTH/2) pooled pixels; one queued start request may wait behind the active pass.
module maxpool_2x2_line #(
    parameter int BD      = 18,
    parameter int INWIDTH = 1918,
    parameter int AW      = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sel,
    input  logic [3*BD-1:0]   q0,
    input  logic [3*BD-1:0]   q1,
    input  logic [3*BD-1:0]   q2,
    input  logic [3*BD-1:0]   q3,
    output logic              rden,
    output logic [AW-1:0]     rdaddr,
    output logic              pool_valid,
    output logic [3*BD-1:0]   pool_data,
    output logic [AW-2:0]     pool_addr,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int              NPOOL     = INWIDTH / 2;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(INWIDTH - 1);
    localparam logic [AW-2:0]   LAST_K    = (AW-1)'(NPOOL - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state, next_state;
    logic              pend_full, pend_sel, sel_r;
    logic              accept, last_seen;
    logic              pend_full_nxt, rden_nxt, busy_nxt, done_nxt, overrun_nxt;
    logic [AW-1:0]     rdaddr_nxt;
    logic              vld_p0;
    logic [AW-1:0]     col_p0;
    logic [3*BD-1:0]   top_p0, bot_p0, pair_max_p0;
    logic [3*BD-1:0]   hold_p1;

    function automatic logic [3*BD-1:0] chan_max(input logic [3*BD-1:0] a, input logic [3*BD-1:0] b);
        logic [3*BD-1:0]   res;
        logic signed [BD-1:0] x, y;
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            x = a[ch*BD +: BD];
            y = b[ch*BD +: BD];
            res[ch*BD +: BD] = (x > y) ? x : y;
        end
        return res;
    endfunction

    // A queued request is served from IDLE exactly like a fresh start.
    assign accept    = (state == IDLE) && (start || pend_full);
    assign last_seen = (state == DRAIN) && pool_valid && (pool_addr == LAST_K);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = READ;
            READ:    if (rdaddr == LAST_ADDR) next_state = DRAIN;
            DRAIN:   if (last_seen) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rden_nxt      = (next_state == READ);
        rdaddr_nxt    = (state == READ && next_state == READ) ? rdaddr + 1'b1 : '0;
        pend_full_nxt = (state != IDLE) && (pend_full || start);
        busy_nxt      = (next_state != IDLE) || pend_full_nxt;
        done_nxt      = last_seen;
        overrun_nxt   = start && pend_full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rden      <= 1'b0;
            rdaddr    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            pend_full <= 1'b0;
            pend_sel  <= 1'b0;
            sel_r     <= 1'b0;
        end else begin
            rden      <= rden_nxt;
            rdaddr    <= rdaddr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            overrun   <= overrun_nxt;
            pend_full <= pend_full_nxt;
            if (state != IDLE && start && !pend_full) pend_sel <= sel;
            if (accept) sel_r <= pend_full ? pend_sel : sel;
        end
    end

    // Stage p0: BRAM data for column col_p0 is on q* this cycle.
    assign top_p0      = sel_r ? q2 : q0;
    assign bot_p0      = sel_r ? q3 : q1;
    assign pair_max_p0 = chan_max(top_p0, bot_p0);

    always_ff @(posedge clk) begin
        col_p0 <= rdaddr;
        if (vld_p0 && !col_p0[0]) hold_p1 <= pair_max_p0;
    end

    // Stage p1: even column parked in hold_p1, odd column completes the 2x2 window.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0     <= 1'b0;
            pool_valid <= 1'b0;
            pool_data  <= '0;
            pool_addr  <= '0;
        end else begin
            vld_p0     <= rden;
            pool_valid <= vld_p0 && col_p0[0];
            if (vld_p0 && col_p0[0]) begin
                pool_data <= chan_max(hold_p1, pair_max_p0);
                pool_addr <= col_p0[AW-1:1];
            end
        end
    end

endmodule

// File: tb/tb_maxpool_2x2_line.sv
// Scoreboard bench for maxpool_2x2_line: an even-width (8) and an odd-width (7) instance,
// each fed by behavioural BRAM models and checked against a plain-arithmetic pooling model.
module tb_maxpool_2x2_line;
    localparam int BD = 18;
    localparam int W  = 3*BD;
    localparam int AW = 4;
    localparam int WA = 8;
    localparam int WB = 7;

    typedef struct {int k; logic [W-1:0] d;} exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          start_a = 1'b0, sel_a = 1'b0, start_b = 1'b0, sel_b = 1'b0;
    logic [W-1:0]  qa0, qa1, qa2, qa3, qb0, qb1, qb2, qb3;
    logic          rden_a, pv_a, busy_a, done_a, ovr_a;
    logic          rden_b, pv_b, busy_b, done_b, ovr_b;
    logic [AW-1:0] rdaddr_a, rdaddr_b;
    logic [W-1:0]  pd_a, pd_b;
    logic [AW-2:0] pa_a, pa_b;

    maxpool_2x2_line #(.BD(BD), .INWIDTH(WA), .AW(AW)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .sel(sel_a),
        .q0(qa0), .q1(qa1), .q2(qa2), .q3(qa3),
        .rden(rden_a), .rdaddr(rdaddr_a), .pool_valid(pv_a), .pool_data(pd_a),
        .pool_addr(pa_a), .busy(busy_a), .done(done_a), .overrun(ovr_a));

    maxpool_2x2_line #(.BD(BD), .INWIDTH(WB), .AW(AW)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .sel(sel_b),
        .q0(qb0), .q1(qb1), .q2(qb2), .q3(qb3),
        .rden(rden_b), .rdaddr(rdaddr_b), .pool_valid(pv_b), .pool_data(pd_b),
        .pool_addr(pa_b), .busy(busy_b), .done(done_b), .overrun(ovr_b));

    logic [W-1:0] ma[4][WA];
    logic [W-1:0] mb[4][WB];
    exp_t qexp_a[$];
    exp_t qexp_b[$];

    int checks = 0, passes = 0, cyc = 0;
    int rd_cyc_a[WA];
    int last_v_a = -100, outs_b = 0, ovr_cnt_a = 0, max_rd_b = 0;

    // Behavioural BRAMs, one-cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rden_a) begin
            qa0 <= ma[0][rdaddr_a[2:0]]; qa1 <= ma[1][rdaddr_a[2:0]];
            qa2 <= ma[2][rdaddr_a[2:0]]; qa3 <= ma[3][rdaddr_a[2:0]];
        end
        if (rden_b) begin
            qb0 <= mb[0][rdaddr_b[2:0]]; qb1 <= mb[1][rdaddr_b[2:0]];
            qb2 <= mb[2][rdaddr_b[2:0]]; qb3 <= mb[3][rdaddr_b[2:0]];
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int sx(input logic [W-1:0] v, input int ch);
        logic [BD-1:0] f;
        f = v[ch*BD +: BD];
        return int'($signed(f));
    endfunction

    // Max over the four samples of a 2x2 window, per channel, as signed integers
    function automatic logic [W-1:0] pool4(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W-1:0] r;
        int m;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            m = sx(a, ch);
            if (sx(b, ch) > m) m = sx(b, ch);
            if (sx(c, ch) > m) m = sx(c, ch);
            if (sx(d, ch) > m) m = sx(d, ch);
            r[ch*BD +: BD] = m[BD-1:0];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] pk(input int a, input int b, input int c);
        return {a[BD-1:0], b[BD-1:0], c[BD-1:0]};
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    task automatic fill_rand_a();
        for (int r = 0; r < 4; r++) for (int c = 0; c < WA; c++) ma[r][c] = rnd();
    endtask

    task automatic push_a(input bit s);
        exp_t e;
        for (int k = 0; k < WA/2; k++) begin
            e.k = k;
            if (s) e.d = pool4(ma[2][2*k], ma[2][2*k+1], ma[3][2*k], ma[3][2*k+1]);
            else   e.d = pool4(ma[0][2*k], ma[0][2*k+1], ma[1][2*k], ma[1][2*k+1]);
            qexp_a.push_back(e);
        end
    endtask

    task automatic push_b(input bit s);
        exp_t e;
        for (int k = 0; k < WB/2; k++) begin
            e.k = k;
            if (s) e.d = pool4(mb[2][2*k], mb[2][2*k+1], mb[3][2*k], mb[3][2*k+1]);
            else   e.d = pool4(mb[0][2*k], mb[0][2*k+1], mb[1][2*k], mb[1][2*k+1]);
            qexp_b.push_back(e);
        end
    endtask

    task automatic pulse_a(input bit s);
        @(negedge clk); start_a = 1'b1; sel_a = s;
        @(negedge clk); start_a = 1'b0; sel_a = ~s;
    endtask

    task automatic wait_done_a(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_a) seen = 1'b1;
        end
        check("done_seen_a", seen, 1);
        check("busy_low_at_done_a", busy_a, 0);
        check("queue_drained_a", qexp_a.size(), 0);
    endtask

    // Monitors: pop the scoreboard whenever the DUT presents a pooled pixel
    always @(negedge clk) begin
        if (!reset) begin
            if (rden_a) rd_cyc_a[rdaddr_a[2:0]] <= cyc;
            if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
            if (rden_b && int'(rdaddr_b) > max_rd_b) max_rd_b <= int'(rdaddr_b);
            if (pv_a) begin
                if (qexp_a.size() == 0) check("unexpected_pool_a", 1, 0);
                else begin
                    check("pool_data_a", pd_a, qexp_a[0].d);
                    check("pool_addr_a", pa_a, qexp_a[0].k);
                    check("latency_a", cyc - rd_cyc_a[2*qexp_a[0].k], 3);
                    void'(qexp_a.pop_front());
                end
                last_v_a <= cyc;
            end
            if (done_a) check("done_after_last_a", cyc, last_v_a + 1);
            if (pv_b) begin
                if (qexp_b.size() == 0) check("unexpected_pool_b", 1, 0);
                else begin
                    check("pool_data_b", pd_b, qexp_b[0].d);
                    check("pool_addr_b", pa_b, qexp_b[0].k);
                    void'(qexp_b.pop_front());
                end
                outs_b <= outs_b + 1;
            end
        end
    end

    initial begin
        bit found, drop, chk_next;
        int dones, ovr0;
        fill_rand_a();
        for (int r = 0; r < 4; r++) for (int c = 0; c < WB; c++) mb[r][c] = rnd();
        repeat (3) @(negedge clk);
        check("reset_pool_data_a", pd_a, 0);
        check("reset_ctrl_a", {rden_a, rdaddr_a, pv_a, pa_a, busy_a, done_a, ovr_a}, 0);
        check("reset_ctrl_b", {rden_b, rdaddr_b, pv_b, pa_b, busy_b, done_b, ovr_b}, 0);
        reset = 1'b0;

        // Ramp pair: expected 11+2k on every channel
        for (int c = 0; c < WA; c++) begin
            ma[0][c] = pk(c, c, c);
            ma[1][c] = pk(10 + c, 10 + c, 10 + c);
        end
        push_a(0); pulse_a(0); wait_done_a(40);

        // Signed window in column pair 2/3
        fill_rand_a();
        ma[0][2] = pk(-5, -1, 3);  ma[0][3] = pk(-5, -1, 3);
        ma[1][2] = pk(-7, -2, -9); ma[1][3] = pk(-7, -2, -9);
        push_a(0); pulse_a(0); wait_done_a(40);

        // sel=1: q0/q1 full of all-ones, only q2/q3 ramp may appear
        for (int c = 0; c < WA; c++) begin
            ma[0][c] = '1; ma[1][c] = '1;
            ma[2][c] = pk(3*c, 100 - c, -c);
            ma[3][c] = pk(c, 50 + c, -2*c);
        end
        push_a(1); pulse_a(1); wait_done_a(40);

        for (int p = 0; p < 4; p++) begin
            bit s;
            s = 1'($urandom_range(0, 1));
            fill_rand_a();
            push_a(s); pulse_a(s); wait_done_a(40);
        end

        // Back-to-back: second start queues, third overruns
        fill_rand_a();
        ovr0 = ovr_cnt_a; dones = 0; drop = 1'b0; chk_next = 1'b0;
        push_a(0);
        @(negedge clk); start_a = 1'b1; sel_a = 1'b0;
        @(negedge clk); start_a = 1'b0;
        for (int i = 0; i < 80 && dones < 2; i++) begin
            @(negedge clk);
            if (chk_next) begin
                check("pending_rdaddr0_a", {rden_a, rdaddr_a}, {1'b1, {AW{1'b0}}});
                chk_next = 1'b0;
            end
            if (done_a) begin
                dones++;
                if (dones == 1) chk_next = 1'b1;
            end
            if (!busy_a && !(done_a && dones == 2)) drop = 1'b1;
            start_a = 1'b0;
            if (i == 3) begin start_a = 1'b1; sel_a = 1'b1; push_a(1); end
            if (i == 7) begin start_a = 1'b1; sel_a = 1'b0; end
        end
        start_a = 1'b0;
        check("b2b_two_dones_a", dones, 2);
        check("b2b_busy_no_gap_a", drop, 0);
        @(negedge clk);
        check("b2b_overrun_once_a", ovr_cnt_a - ovr0, 1);
        check("b2b_queue_drained_a", qexp_a.size(), 0);

        // Reset mid-pass at rdaddr=3 aborts cleanly
        fill_rand_a();
        push_a(0); pulse_a(0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (rden_a && rdaddr_a == 3) found = 1'b1;
            else @(negedge clk);
        end
        check("reached_rdaddr3_a", found, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_pool_data_a", pd_a, 0);
        check("midreset_ctrl_a", {rden_a, rdaddr_a, pv_a, pa_a, busy_a, done_a, ovr_a}, 0);
        reset = 1'b0;
        qexp_a.delete();
        repeat (15) @(negedge clk);
        fill_rand_a();
        push_a(1); pulse_a(1); wait_done_a(40);

        // Odd width: last column read but discarded
        begin
            bit s, seen;
            s = 1'($urandom_range(0, 1));
            push_b(s);
            @(negedge clk); start_b = 1'b1; sel_b = s;
            @(negedge clk); start_b = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (done_b) seen = 1'b1;
            end
            check("done_seen_b", seen, 1);
            check("odd_output_count_b", outs_b, 3);
            check("odd_max_rdaddr_b", max_rd_b, 6);
            check("queue_drained_b", qexp_b.size(), 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
